vote_capture: RTL

Front-end stage of the voting system: it feeds the per-candidate vote counters. It debounces N_CAND raw candidate buttons and enforces one vote per arming by the poll officer. For each accepted vote it emits exactly one single-cycle `up` pulse to the chosen candidate's counter. Ambiguous input (two or more buttons pressed together) is rejected and flagged.

---
 rtl/vote_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 39 +++
 rtl/vote_capture.sv | 91 +++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the voting front end and the vote counters.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2
  } vc_state_t;

  localparam int N_CAND_DEF     = 4;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int CNT_W          = 21;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer followed by a counter debouncer.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // cnt counts edges on which sync2 disagreed with deb; the level flips on the
  // edge after DEB_CYCLES such edges, any agreeing cycle starts over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vote_capture.sv
// Debounces candidate buttons, allows one vote per arming, emits one-hot up pulses.
module vote_capture
  import vote_pkg::*;
#(
  parameter int N_CAND     = N_CAND_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [N_CAND-1:0] btn,
  output logic [N_CAND-1:0] up,
  output logic              ready,
  output logic              reject,
  output logic [1:0]        fsm_state
);

  logic [N_CAND-1:0] deb;
  logic [N_CAND-1:0] deb_q;
  logic [N_CAND-1:0] press;
  logic [4:0]        pc;
  vc_state_t         state;
  vc_state_t         state_nx;
  logic [N_CAND-1:0] up_nx;
  logic              reject_nx;
  logic              owed;

  for (genvar i = 0; i < N_CAND; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn[i]),
      .deb   (deb[i])
    );
  end

  assign press     = deb & ~deb_q;
  assign pc        = popcount16(16'(deb));
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm) state_nx = ARMED;
      ARMED:   if (pc >= 5'd2 || (pc == 5'd1 && |press)) state_nx = RELEASE;
      RELEASE: if (deb == '0) state_nx = owed ? ARMED : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A held button never produces press, so it cannot vote until re-pressed.
  always_comb begin
    up_nx     = '0;
    reject_nx = 1'b0;
    ready     = (state == ARMED);
    if (state == ARMED) begin
      if (pc >= 5'd2) begin
        reject_nx = 1'b1;
      end else if (pc == 5'd1 && |press) begin
        up_nx = deb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q  <= '0;
      up     <= '0;
      reject <= 1'b0;
      owed   <= 1'b0;
    end else begin
      deb_q  <= deb;
      up     <= up_nx;
      reject <= reject_nx;
      if (reject_nx) begin
        owed <= 1'b1;
      end else if (|up_nx) begin
        owed <= 1'b0;
      end
    end
  end

endmodule
